seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller that shares one 7-segment bus across NUM_DIGITS digits.

---
 rtl/seg_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: cycles NUM_DIGITS digits with a blanking gap,
// double-buffering digit values so a frame is never shown with mixed old/new data.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYCLES  = 1000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [3*NUM_DIGITS-1:0] wr_data,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_ON, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [3*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    frame_done_q, frame_done_d;
  logic                    boundary;
  logic                    accept;
  logic [DW-1:0]           next_digit;
  logic                    digit_wrap;

  function automatic logic [6:0] dec7(input logic [2:0] v);
    case (v)
      3'd0:    dec7 = 7'b0000001;
      3'd1:    dec7 = 7'b1001111;
      3'd2:    dec7 = 7'b0010010;
      3'd3:    dec7 = 7'b0000110;
      3'd4:    dec7 = 7'b1001100;
      3'd5:    dec7 = 7'b0100100;
      3'd6:    dec7 = 7'b0100000;
      default: dec7 = 7'b0001111;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    boundary     = 1'b0;
    accept       = wr_valid & wr_ready_q;
    digit_wrap   = (digit_q == LAST_DIGIT);
    next_digit   = digit_wrap ? '0 : digit_q + 1'b1;

    if (!en) begin
      state_d = S_OFF;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_ON;
          digit_d = '0;
          cnt_d   = '0;
        end
        S_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_d = '0;
            // With no gap, the next digit lights on the very next cycle.
            if (GAP_CYCLES == 0) begin
              digit_d  = next_digit;
              boundary = digit_wrap;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d    = '0;
            state_d  = S_ON;
            digit_d  = next_digit;
            boundary = digit_wrap;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // disp only changes while dark, at OFF entry, or on the frame boundary edge.
    if (state_q == S_OFF) begin
      if (accept) disp_d = wr_data;
    end else if (state_d == S_OFF || boundary) begin
      if (pend_full_q) begin
        disp_d      = pend_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        disp_d = wr_data;
      end
    end else if (accept) begin
      pend_d      = wr_data;
      pend_full_d = 1'b1;
    end

    an_d  = '1;
    seg_d = 7'h7F;
    if (state_d == S_ON) begin
      an_d[digit_d] = 1'b0;
      seg_d         = dec7(disp_d[3*digit_d +: 3]);
    end
    wr_ready_d   = !pend_full_d;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_OFF;
      digit_q      <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
      wr_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      wr_ready_q   <= wr_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign wr_ready   = wr_ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: main instance with a 2-cycle gap, second instance with no gap.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic [11:0] wr_data = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        wr_ready;
  logic        frame_done;

  logic        en2 = 1'b0;
  logic [6:0]  seg2;
  logic [3:0]  an2;
  logic        wr_ready2;
  logic        frame_done2;

  int n_checks = 0;
  int n_pass   = 0;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  seg_scan_ctrl #(.NUM_DIGITS(4), .ON_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .seg(seg), .an(an), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .ON_CYCLES(4), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst(rst), .en(en2), .wr_valid(1'b0), .wr_ready(wr_ready2),
    .wr_data(12'h000), .seg(seg2), .an(an2), .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd0:    seg_of = 7'b0000001;
      3'd1:    seg_of = 7'b1001111;
      3'd2:    seg_of = 7'b0010010;
      3'd3:    seg_of = 7'b0000110;
      3'd4:    seg_of = 7'b1001100;
      3'd5:    seg_of = 7'b0100100;
      3'd6:    seg_of = 7'b0100000;
      default: seg_of = 7'b0001111;
    endcase
  endfunction

  // Edge e (1-based) of a 24-cycle frame: 4 lit cycles then 2 blank per digit.
  task automatic chk_scan(input string tag, input int e, input logic [11:0] data);
    int p, d;
    logic [3:0] ea;
    logic [6:0] es;
    logic [11:0] dv;
    p  = (e - 1) % 6;
    d  = ((e - 1) / 6) % 4;
    ea = 4'hF;
    es = 7'h7F;
    dv = data;
    if (p < 4) begin
      ea[d] = 1'b0;
      es    = seg_of(dv[3*d +: 3]);
    end
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  initial begin
    // 1. reset
    #12;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_seg", 32'(seg), 32'h7F);
    chk("idle_an", 32'(an), 32'hF);

    // 2. load while off, then scan the first frame
    wr_data  = 12'o3210;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("off_wr_ready", 32'(wr_ready), 32'd1);
    chk("off_wr_an", 32'(an), 32'hF);
    en = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk_scan("f1", e, 12'o3210);
      chk("f1_fd", 32'(frame_done), 32'd0);
      if (e >= 9) chk("f1_ready_low", 32'(wr_ready), 32'd0);
      // 3. mid-frame write accepted at edge 8, second write stalls from edge 21
      if (e == 7) begin
        wr_valid = 1'b1;
        wr_data  = 12'o7654;
      end
      if (e == 8) begin
        wr_valid = 1'b0;
        chk("wr8_ready", 32'(wr_ready), 32'd0);
      end
      if (e == 20) begin
        wr_valid = 1'b1;
        wr_data  = 12'o2301;
      end
    end
    tick();
    chk("e25_an", 32'(an), 32'hE);
    chk("e25_seg", 32'(seg), 32'b1001100);
    chk("e25_fd", 32'(frame_done), 32'd1);
    chk("e25_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("e26_fd", 32'(frame_done), 32'd0);
    chk("e26_ready", 32'(wr_ready), 32'd0);
    chk_scan("e26", 2, 12'o7654);
    for (int e = 27; e <= 31; e++) begin
      tick();
      chk_scan("f2", e - 24, 12'o7654);
    end

    // 4. disable during digit 1 ON; pending commits at OFF entry
    en = 1'b0;
    tick();
    chk("off_an", 32'(an), 32'hF);
    chk("off_seg", 32'(seg), 32'h7F);
    chk("off_ready", 32'(wr_ready), 32'd1);
    chk("off_fd", 32'(frame_done), 32'd0);
    tick();
    chk("off2_an", 32'(an), 32'hF);
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_scan("resume", k, 12'o2301);
    end

    // 5. async reset mid-ON with pending full
    wr_valid = 1'b1;
    wr_data  = 12'o5555;
    tick();
    wr_valid = 1'b0;
    chk("pend_ready", 32'(wr_ready), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("arst_hold_an", 32'(an), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk_scan("post_rst", e, 12'o0000);
      chk("post_rst_ready", 32'(wr_ready), 32'd1);
    end
    tick();
    chk("post_rst_fd", 32'(frame_done), 32'd1);
    chk("post_rst_seg", 32'(seg), 32'b0000001);
    chk("post_rst_an", 32'(an), 32'hE);

    // 6. no-gap instance
    en  = 1'b0;
    en2 = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      logic [3:0] ea;
      tick();
      ea = 4'hF;
      ea[((e - 1) / 4) % 4] = 1'b0;
      chk("ng_an", 32'(an2), 32'(ea));
      chk("ng_seg", 32'(seg2), 32'b0000001);
      chk("ng_fd", 32'(frame_done2), (e == 17 || e == 33) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
